cacheline_adapter: RTL and testbench
====================================

Name: cacheline_adapter

Overview:
- Sits between the cache datapath's physical-memory port (256-bit line, single handshake) and the 64-bit burst memory.
- Acts as the responder to the cache's pmem_read/pmem_write requests and as the initiator of 4-beat bursts to memory.
- Collects read beats into a full line and serializes write lines into beats.
- Returns a single-cycle response to the cache when the whole line has transferred.

Parameters:
LINE_W, 256, cacheline width in bits
BURST_W, 64, burst beat width in bits; BEATS = LINE_W/BURST_W = 4
OFFSET_W, 5, address offset bits forced to zero on address_o

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted at 0)
pmem_address  in  32  line address from cache
pmem_read  in  1  read request, held until pmem_resp
pmem_write  in  1  write request, held until pmem_resp
pmem_wdata  in  LINE_W  line to write
pmem_rdata  out  LINE_W  assembled read line
pmem_resp  out  1  one-cycle completion pulse
burst_address  out  32  burst address, low OFFSET_W bits zero
burst_read  out  1  burst read request
burst_write  out  1  burst write request
burst_wdata  out  BURST_W  current write beat
burst_rdata  in  BURST_W  incoming read beat
burst_resp  in  1  beat strobe: one beat transferred this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; beat counter 0; line buffer 0; address register 0.
  - All outputs read 0: pmem_rdata, pmem_resp, burst_read, burst_write, burst_wdata, burst_address.
  - Reset asserted mid-burst aborts the transfer immediately; no pmem_resp is issued.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On a clock edge with pmem_read=1, latch pmem_address with the low OFFSET_W bits zeroed, clear the counter, go to READ.
  - On a clock edge with pmem_write=1 (and pmem_read=0), also latch pmem_wdata into the line buffer and go to WRITE.
  - pmem_read and pmem_write both high is a protocol violation; read wins.
  - burst_resp is ignored in IDLE.
- READ:
  - burst_read=1 (Moore output).
  - Each cycle with burst_resp=1 writes burst_rdata into buffer slice [64*k +: 64], where k = counter, then increments k.
  - The beat with k=3 goes to DONE.
  - Cycles with burst_resp=0 are gaps: hold state and counter.
- WRITE:
  - burst_write=1; burst_wdata = buffer slice k.
  - Each burst_resp=1 increments k; the beat with k=3 goes to DONE.
  - Gaps are allowed, as in READ.
- DONE:
  - pmem_resp=1 for exactly one cycle, then IDLE unconditionally.
  - pmem_read/pmem_write are not sampled in DONE; the cache deasserts in the cycle after pmem_resp.
- Outputs and latency:
  - pmem_rdata is driven from the line buffer.
  - It is valid and stable from the DONE cycle until the next request is accepted.
  - burst_address is driven from the address register and is stable for the whole burst.
  - Latency: a request seen at edge 0 asserts burst_read/burst_write after edge 0.
  - With back-to-back beats at edges 1–4, pmem_resp is high in the cycle after edge 4 and the adapter is back in IDLE after edge 5.
  - Minimum turnaround is 6 cycles per line.
- Counter: 2 bits, wraps 3→0 on the final beat; no further beats are accepted after wrap.
- Request changes after acceptance: pmem_address and pmem_wdata changes are ignored, since both are latched.

Test Plan:
- Read, no gaps:
  - Stimulus: pmem_read=1, pmem_address=0x1234_5678; memory returns 0x1111…, 0x2222…, 0x3333…, 0x4444… on consecutive cycles.
  - Required: burst_address=0x1234_5660; pmem_rdata=0x4444…_3333…_2222…_1111…; one pmem_resp pulse 5 cycles after acceptance.
- Read with gaps: burst_resp pattern 1,0,0,1,0,1,1 -> identical line assembled; pmem_resp only after the 4th strobe; burst_read held throughout.
- Write:
  - Stimulus: pmem_wdata=0xDDDD…_CCCC…_BBBB…_AAAA…, pmem_write=1, and pmem_wdata changed to 0 the cycle after acceptance.
  - Required: burst_wdata sequence AAAA, BBBB, CCCC, DDDD; then a single pmem_resp.
- Reset mid-read: rst=0 after 2 beats -> burst_read falls without a clock edge, pmem_rdata=0, no pmem_resp; a new read afterwards completes normally.
- Simultaneous read and write: pmem_read=pmem_write=1 -> burst_read=1, burst_write=0 for the whole transfer.
- Idle noise: burst_resp toggled while IDLE -> no state change, no pmem_resp, pmem_rdata unchanged.

Source files
------------

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: bridges a 256-bit single-handshake cache port to a 64-bit 4-beat burst memory.
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   pmem_*        cache side: line address, read/write requests, write line, read line, one-cycle response
//   burst_*       memory side: line-aligned address, read/write requests, write beat, read beat, beat strobe
module cacheline_adapter #(
  parameter int LINE_W   = 256,
  parameter int BURST_W  = 64,
  parameter int OFFSET_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pmem_address,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic [31:0]        burst_address,
  output logic               burst_read,
  output logic               burst_write,
  output logic [BURST_W-1:0] burst_wdata,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [LINE_W-1:0]  r_buf;
  logic [31:0]        r_addr;
  logic               w_last;
  assign w_last = burst_resp && (r_cnt == CNT_W'(BEATS - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  // read has priority over write when both are requested
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:        w_next = pmem_read ? READ : pmem_write ? WRITE : IDLE;
      READ, WRITE: w_next = w_last ? DONE : r_state;
      DONE:        w_next = IDLE;
    endcase
  end
  // the counter wraps to 0 on the final beat, leaving it cleared for the next line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_buf  <= '0;
      r_addr <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (pmem_read || pmem_write) begin
          r_addr <= pmem_address & ~((32'd1 << OFFSET_W) - 32'd1);
          r_cnt  <= '0;
          if (!pmem_read) r_buf <= pmem_wdata;
        end
        READ: if (burst_resp) begin
          r_buf[int'(r_cnt)*BURST_W +: BURST_W] <= burst_rdata;
          r_cnt <= r_cnt + 1'b1;
        end
        WRITE: if (burst_resp) r_cnt <= r_cnt + 1'b1;
        DONE: ;
      endcase
    end
  end
  always_comb begin
    pmem_resp   = r_state == DONE;
    burst_read  = r_state == READ;
    burst_write = r_state == WRITE;
    burst_wdata = burst_write ? r_buf[int'(r_cnt)*BURST_W +: BURST_W] : '0;
  end
  assign pmem_rdata    = r_buf;
  assign burst_address = r_addr;
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: randomized self-checking bench with a transaction-level model of the adapter.
module tb_cacheline_adapter;
  logic         clk, rst;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  burst_address;
  logic         burst_read, burst_write;
  logic [63:0]  burst_wdata, burst_rdata;
  logic         burst_resp;
  int           n_tests, n_fail;
  logic [63:0]  beats [4];
  logic [255:0] last_line;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .burst_address(burst_address), .burst_read(burst_read), .burst_write(burst_write),
    .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] line_addr(input logic [31:0] a);
    return (a >> 5) << 5;
  endfunction

  // Beats come from the global beats[] array; pat/plen give the strobe pattern (1 after plen).
  task automatic do_read(input logic [31:0] addr, input logic [15:0] pat, input int plen, input logic also_wr);
    logic [255:0] exp_line;
    int got, idx;
    exp_line = {beats[3], beats[2], beats[1], beats[0]};
    pmem_read = 1'b1; pmem_write = also_wr; pmem_address = addr;
    pmem_wdata = {8{$urandom}};
    @(negedge clk);
    pmem_address = $urandom;
    pmem_wdata = {8{$urandom}};
    got = 0; idx = 0;
    while (got < 4) begin
      check("rd_ctl", 256'({burst_read, burst_write, pmem_resp}), 256'(3'b100));
      check("rd_addr", 256'(burst_address), 256'(line_addr(addr)));
      burst_resp  = (idx < plen) ? pat[idx] : 1'b1;
      burst_rdata = burst_resp ? beats[got] : {$urandom, $urandom};
      if (burst_resp) got++;
      idx++;
      @(negedge clk);
    end
    burst_resp = 1'b0;
    check("rd_resp", 256'(pmem_resp), 256'(1));
    check("rd_line", pmem_rdata, exp_line);
    pmem_read = 1'b0; pmem_write = 1'b0;
    @(negedge clk);
    check("rd_after", 256'({burst_read, burst_write, pmem_resp}), 256'(0));
    check("rd_hold", pmem_rdata, exp_line);
    last_line = exp_line;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input logic [15:0] pat, input int plen);
    int got, idx;
    pmem_write = 1'b1; pmem_address = addr; pmem_wdata = line;
    @(negedge clk);
    pmem_wdata = '0; pmem_address = $urandom;
    got = 0; idx = 0;
    while (got < 4) begin
      check("wr_ctl", 256'({burst_read, burst_write, pmem_resp}), 256'(3'b010));
      check("wr_addr", 256'(burst_address), 256'(line_addr(addr)));
      check("wr_beat", 256'(burst_wdata), 256'(line[64*got +: 64]));
      burst_resp  = (idx < plen) ? pat[idx] : 1'b1;
      burst_rdata = {$urandom, $urandom};
      if (burst_resp) got++;
      idx++;
      @(negedge clk);
    end
    burst_resp = 1'b0;
    check("wr_resp", 256'(pmem_resp), 256'(1));
    pmem_write = 1'b0;
    @(negedge clk);
    check("wr_after", 256'({burst_read, burst_write, pmem_resp}), 256'(0));
    last_line = line;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; last_line = '0;
    rst = 1'b0; pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl", 256'({burst_read, burst_write, pmem_resp}), 256'(0));
    check("rst_rdata", pmem_rdata, 256'(0));
    check("rst_wdata", 256'(burst_wdata), 256'(0));
    check("rst_addr", 256'(burst_address), 256'(0));
    rst = 1'b1;
    @(negedge clk);

    beats[0] = {16{4'h1}}; beats[1] = {16{4'h2}}; beats[2] = {16{4'h3}}; beats[3] = {16{4'h4}};
    do_read(32'h1234_5678, 16'h0000, 0, 1'b0);
    check("rd_plan_addr", 256'(burst_address), 256'(32'h1234_5660));

    do_read(32'h0000_ABCD, 16'h0069, 7, 1'b0);

    do_write(32'hCAFE_F00D, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 16'h0000, 0);

    // reset in the middle of a read, after two beats
    pmem_read = 1'b1; pmem_address = 32'h5555_5555;
    @(negedge clk);
    burst_resp = 1'b1; burst_rdata = {2{$urandom}};
    @(negedge clk);
    burst_rdata = {2{$urandom}};
    @(negedge clk);
    burst_resp = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ctl", 256'({burst_read, burst_write, pmem_resp}), 256'(0));
    check("mid_rst_rdata", pmem_rdata, 256'(0));
    check("mid_rst_addr", 256'(burst_address), 256'(0));
    pmem_read = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_resp", 256'(pmem_resp), 256'(0));
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
    do_read(32'h0BAD_BEEF, 16'h0000, 0, 1'b0);

    for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
    do_read(32'h7777_0011, 16'h0005, 4, 1'b1);

    for (int i = 0; i < 8; i++) begin
      burst_resp = 1'($urandom); burst_rdata = {$urandom, $urandom};
      @(negedge clk);
      check("idle_ctl", 256'({burst_read, burst_write, pmem_resp}), 256'(0));
      check("idle_rdata", pmem_rdata, last_line);
    end
    burst_resp = 1'b0;

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 4; i++) beats[i] = {$urandom, $urandom};
        do_read($urandom, 16'($urandom), $urandom_range(0, 12), 1'($urandom));
      end else begin
        do_write($urandom, {8{$urandom}}, 16'($urandom), $urandom_range(0, 12));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
